// File: rtl/cpu_step_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_step_sequencer_pkg
// Definitions shared by the step sequencer and the control unit that sits
// after it.
//   step_t     : 2-bit step encoding T0..T3 (the value seen on the state port)
//   OPC_*      : 3-bit opcode constants
//   MAX_OPC    : highest legal opcode; anything above it is illegal
//   opc_legal  : helper that compares an opcode against a legality limit
// -----------------------------------------------------------------------------
package cpu_step_sequencer_pkg;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } step_t;

    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_MVI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;
    localparam logic [2:0] OPC_MVO = 3'b100;

    localparam logic [2:0] MAX_OPC = OPC_MVO;

    function automatic logic opc_legal(input logic [2:0] opc, input logic [2:0] max_opc);
        return (opc <= max_opc);
    endfunction

endpackage

// File: rtl/cpu_step_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Enable-driven up counter that stops at all-ones instead of wrapping.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset, clears the count to zero
//   en_i     : add one on this clock edge (ignored once saturated)
//   count_o  : current count, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_step_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_step_sequencer
// Upstream stage of the processor control path. It owns the T0..T3 step
// counter and the instruction register, and it advances or retires the
// current instruction based on ir_en and done from the control unit. It also
// flags illegal opcodes and counts retired instructions.
//   clk         : system clock, rising edge
//   reset       : asynchronous active-high reset
//   run         : start request; only looked at in T0
//   din         : instruction word from the bus
//   ir_en       : IR load enable from the control unit; only looked at in T0
//   done        : the current instruction completes in this step
//   clear_err   : synchronous clear of the sticky illegal flag
//   state       : current step (00=T0 .. 11=T3)
//   ir          : registered instruction
//   busy        : high whenever state is not T0
//   retire      : one-cycle pulse in the first T0 after an instruction finishes
//   illegal     : sticky illegal-opcode flag
//   instr_count : saturating count of retired instructions
// -----------------------------------------------------------------------------
module cpu_step_sequencer
    import cpu_step_sequencer_pkg::*;
#(
    parameter int         IR_W    = 9,
    parameter int         CNT_W   = 16,
    parameter logic [2:0] MAX_OPC = cpu_step_sequencer_pkg::MAX_OPC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [IR_W-1:0]  din,
    input  logic             ir_en,
    input  logic             done,
    input  logic             clear_err,
    output logic [1:0]       state,
    output logic [IR_W-1:0]  ir,
    output logic             busy,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    step_t           state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            retire_q, retire_d;
    logic            illegal_q, illegal_d;
    logic            illegal_set;
    logic [2:0]      opcode;

    assign opcode = ir_q[IR_W-1 -: 3];

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        retire_d    = 1'b0;
        illegal_set = 1'b0;
        case (state_q)
            T0: begin
                // done is meaningless here; only a run+ir_en pair starts work.
                if (run && ir_en) begin
                    ir_d    = din;
                    state_d = T1;
                end
            end
            T1: begin
                // An illegal opcode aborts before done is considered, so it
                // can never be mistaken for a retirement.
                if (!opc_legal(opcode, MAX_OPC)) begin
                    illegal_set = 1'b1;
                    state_d     = T0;
                end else if (done) begin
                    retire_d = 1'b1;
                    state_d  = T0;
                end else begin
                    state_d = T2;
                end
            end
            T2: begin
                if (done) begin
                    retire_d = 1'b1;
                    state_d  = T0;
                end else begin
                    state_d = T3;
                end
            end
            T3: begin
                retire_d = 1'b1;
                state_d  = T0;
            end
            default: begin
                state_d = T0;
            end
        endcase
        // A new detection takes priority over a simultaneous clear.
        illegal_d = illegal_set | (illegal_q & ~clear_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= T0;
            ir_q      <= '0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
        end
    end

    // The counter advances on the same edge that raises retire, so the
    // count already includes the instruction while its pulse is visible.
    sat_counter #(
        .W (CNT_W)
    ) u_retire_cnt (
        .clk     (clk),
        .rst     (reset),
        .en_i    (retire_d),
        .count_o (instr_count)
    );

    assign state   = state_q;
    assign ir      = ir_q;
    assign busy    = (state_q != T0);
    assign retire  = retire_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
module tb_cpu_step_sequencer;

    localparam int IR_W    = 9;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [IR_W-1:0]  din;
    logic             ir_en;
    logic             done;
    logic             clear_err;
    logic [1:0]       state;
    logic [IR_W-1:0]  ir;
    logic             busy;
    logic             retire;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which step of the instruction we are in, plus the
    // architectural values the spec defines.
    int m_step;
    int m_ir;
    int m_retire;
    int m_illegal;
    int m_count;

    cpu_step_sequencer #(
        .IR_W  (IR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .din         (din),
        .ir_en       (ir_en),
        .done        (done),
        .clear_err   (clear_err),
        .state       (state),
        .ir          (ir),
        .busy        (busy),
        .retire      (retire),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_step    = 0;
        m_ir      = 0;
        m_retire  = 0;
        m_illegal = 0;
        m_count   = 0;
    endtask

    task automatic model_clock();
        int opc;
        int finished;
        int bad;
        finished = 0;
        bad      = 0;
        if (m_step == 0) begin
            if (run && ir_en) begin
                m_ir   = int'(din);
                m_step = 1;
            end
        end else begin
            opc = m_ir / 64;
            if (m_step == 1 && opc > 4) begin
                bad    = 1;
                m_step = 0;
            end else if (done || m_step == 3) begin
                finished = 1;
                m_step   = 0;
                if (m_count < CNT_MAX) m_count = m_count + 1;
            end else begin
                m_step = m_step + 1;
            end
        end
        m_retire = finished;
        if (bad) m_illegal = 1;
        else if (clear_err) m_illegal = 0;
    endtask

    task automatic compare_all();
        check("state",   int'(state),       m_step);
        check("ir",      int'(ir),          m_ir);
        check("busy",    int'(busy),        (m_step != 0) ? 1 : 0);
        check("retire",  int'(retire),      m_retire);
        check("illegal", int'(illegal),     m_illegal);
        check("count",   int'(instr_count), m_count);
        if (retire) $display("retire ir=%03h count=%0d t=%0t", ir, instr_count, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_clock();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic r, input logic en, input logic [IR_W-1:0] d,
                         input logic dn, input logic clr);
        run       = r;
        ir_en     = en;
        din       = d;
        done      = dn;
        clear_err = clr;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        drive(0, 0, '0, 0, 0);
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        tick();
        tick();
        reset = 1'b0;
        $display("test reset state done");

        // Reset abandons an instruction sitting in T2.
        drive(1, 1, 9'b000_001_010, 0, 0); tick();
        drive(0, 0, '0, 0, 0);             tick();
        check("mid_state_T2", int'(state), 2);
        apply_reset();
        tick();
        $display("test reset mid-op done");

        // Single-step MV.
        drive(1, 1, 9'b000_011_101, 0, 0); tick();
        check("mv_ir", int'(ir), 'h01D);
        drive(0, 0, '0, 1, 0);             tick();
        drive(0, 0, '0, 0, 0);             tick();
        $display("test single-step MV done");

        // Full ADD, done never asserted.
        drive(1, 1, 9'b010_000_001, 0, 0); tick();
        drive(0, 0, '0, 0, 0);
        repeat (4) tick();
        $display("test full ADD done");

        // Illegal opcode, clear, then set-wins-over-clear.
        drive(1, 1, 9'b110_000_000, 0, 0); tick();
        drive(0, 0, '0, 1, 0);             tick();
        drive(0, 0, '0, 0, 1);             tick();
        drive(1, 1, 9'b111_000_000, 0, 0); tick();
        drive(0, 0, '0, 0, 1);             tick();
        check("set_wins", int'(illegal), 1);
        drive(0, 0, '0, 0, 0);             tick();
        $display("test illegal opcode done");

        // Back-to-back MVs with run held high, then run dropped mid-ADD.
        drive(1, 1, 9'b000_000_001, 0, 0); tick();
        drive(1, 1, 9'b000_000_010, 1, 0); tick();
        drive(1, 1, 9'b000_000_010, 0, 0); tick();
        drive(1, 1, 9'b010_010_010, 1, 0); tick();
        drive(1, 1, 9'b010_010_011, 0, 0); tick();
        drive(1, 1, '0, 0, 0);             tick();
        drive(0, 0, '0, 0, 0);             tick();
        tick();
        repeat (3) tick();
        $display("test back-to-back and run drop done");

        // Saturation of the retired counter.
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 9'b000_000_000, 0, 0); tick();
            drive(0, 0, '0, 1, 0);             tick();
        end
        check("sat_count", int'(instr_count), CNT_MAX);
        drive(0, 0, '0, 0, 0); tick();
        $display("test saturation done");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
                  IR_W'($urandom), logic'($urandom_range(0, 2) == 0),
                  logic'($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 299) == 0) apply_reset();
            else tick();
        end
        $display("test random done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
